// File: rtl/display_panel_receiver.sv
// Panel-side receiver: rebuilds the latched row, lit pixels, on-time
// and protocol error flags from the serial panel signal set.
module display_panel_receiver #(
  parameter int rows       = 8,
  parameter int columns    = 32,
  parameter int countwidth = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         oclk,
  input  logic                         lat,
  input  logic                         oe,
  input  logic [$clog2(rows)-1:0]      row,
  input  logic                         clr,
  output logic [columns-1:0]           latched,
  output logic [$clog2(rows)-1:0]      latched_row,
  output logic [columns-1:0]           lit,
  output logic [$clog2(columns+1)-1:0] shift_count,
  output logic [countwidth-1:0]        last_on_cycles,
  output logic                         row_strobe,
  output logic                         frame_strobe,
  output logic                         err_short,
  output logic                         err_long,
  output logic                         err_lat_oe
);

  localparam int rw = $clog2(rows);
  localparam int sw = $clog2(columns + 1);
  localparam logic [sw-1:0] cnt_full = sw'(columns + 1);
  localparam logic [sw-1:0] cnt_line = sw'(columns);
  localparam logic [rw-1:0] row_last = rw'(rows - 1);
  localparam logic [countwidth-1:0] on_max = '1;

  logic                  oclk_q;
  logic                  lat_q;
  logic [columns-1:0]    sr;
  logic [countwidth-1:0] on_cycles;

  logic                  oclk_rise;
  logic                  lat_rise;
  logic [columns-1:0]    sr_next;
  logic [sw-1:0]         cnt_next;
  logic [countwidth-1:0] on_final;

  assign oclk_rise = oclk & ~oclk_q;
  assign lat_rise  = lat & ~lat_q;

  // post-shift view so a shift coinciding with a latch is captured
  always_comb begin
    sr_next  = sr;
    cnt_next = shift_count;
    if (oclk_rise) begin
      sr_next = {sr[columns-2:0], din};
      if (shift_count != cnt_full)
        cnt_next = shift_count + 1'b1;
    end
  end

  always_comb begin
    on_final = on_cycles;
    if (!oe && on_cycles != on_max)
      on_final = on_cycles + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oclk_q         <= 1'b0;
      lat_q          <= 1'b0;
      sr             <= '0;
      on_cycles      <= '0;
      shift_count    <= '0;
      latched        <= '0;
      latched_row    <= '0;
      lit            <= '0;
      last_on_cycles <= '0;
      row_strobe     <= 1'b0;
      frame_strobe   <= 1'b0;
      err_short      <= 1'b0;
      err_long       <= 1'b0;
      err_lat_oe     <= 1'b0;
    end else begin
      oclk_q       <= oclk;
      lat_q        <= lat;
      sr           <= sr_next;
      lit          <= oe ? '0 : latched;
      row_strobe   <= 1'b0;
      frame_strobe <= 1'b0;
      if (clr) begin
        err_short  <= 1'b0;
        err_long   <= 1'b0;
        err_lat_oe <= 1'b0;
      end
      if (lat_rise) begin
        latched        <= sr_next;
        latched_row    <= row;
        last_on_cycles <= on_final;
        on_cycles      <= '0;
        shift_count    <= '0;
        row_strobe     <= (row != latched_row);
        frame_strobe   <= (latched_row == row_last) && (row == '0);
        if (cnt_next < cnt_line) err_short  <= 1'b1;
        if (cnt_next > cnt_line) err_long   <= 1'b1;
        if (!oe)                 err_lat_oe <= 1'b1;
      end else begin
        shift_count <= cnt_next;
        on_cycles   <= on_final;
      end
    end
  end

endmodule

// File: tb/tb_display_panel_receiver.sv
// Directed bench for display_panel_receiver.
// Inputs change on falling clk edges; outputs are checked there too.
module tb_display_panel_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        oclk;
  logic        lat;
  logic        oe;
  logic [2:0]  row;
  logic        clr;
  logic [31:0] latched;
  logic [2:0]  latched_row;
  logic [31:0] lit;
  logic [5:0]  shift_count;
  logic [15:0] last_on_cycles;
  logic        row_strobe;
  logic        frame_strobe;
  logic        err_short;
  logic        err_long;
  logic        err_lat_oe;

  int checks = 0;
  int passes = 0;
  int rs_cnt = 0;
  int fs_cnt = 0;
  logic count_en = 1'b0;

  always #5 clk = ~clk;

  display_panel_receiver dut (
    .clk            (clk),
    .rst            (rst),
    .din            (din),
    .oclk           (oclk),
    .lat            (lat),
    .oe             (oe),
    .row            (row),
    .clr            (clr),
    .latched        (latched),
    .latched_row    (latched_row),
    .lit            (lit),
    .shift_count    (shift_count),
    .last_on_cycles (last_on_cycles),
    .row_strobe     (row_strobe),
    .frame_strobe   (frame_strobe),
    .err_short      (err_short),
    .err_long       (err_long),
    .err_lat_oe     (err_lat_oe)
  );

  always @(negedge clk) begin
    if (count_en) begin
      if (row_strobe)   rs_cnt++;
      if (frame_strobe) fs_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h required %0h", tag, obs, exp);
  endtask

  task automatic shift_bit(input logic b);
    din  = b;
    oclk = 1'b1;
    tick();
    oclk = 1'b0;
    tick();
  endtask

  task automatic shift_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic latch();
    lat = 1'b1;
    tick();
    lat = 1'b0;
    tick();
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_latched"}, 64'(latched), 64'h0);
    chk({tag, "_row"}, 64'(latched_row), 64'h0);
    chk({tag, "_lit"}, 64'(lit), 64'h0);
    chk({tag, "_cnt"}, 64'(shift_count), 64'h0);
    chk({tag, "_on"}, 64'(last_on_cycles), 64'h0);
    chk({tag, "_strb"}, 64'({row_strobe, frame_strobe}), 64'h0);
    chk({tag, "_errs"}, 64'({err_short, err_long, err_lat_oe}), 64'h0);
  endtask

  logic [31:0] w;

  initial begin
    rst = 1'b1; din = 1'b0; oclk = 1'b0; lat = 1'b0;
    oe = 1'b1; row = 3'd0; clr = 1'b0;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // full line
    w = 32'hA5A500FF;
    shift_word(w, 32);
    chk("full_cnt32", 64'(shift_count), 64'd32);
    row = 3'd3;
    lat = 1'b1;
    tick();
    chk("full_rstrobe", 64'(row_strobe), 64'd1);
    lat = 1'b0;
    tick();
    chk("full_rstrobe_off", 64'(row_strobe), 64'd0);
    chk("full_latched", 64'(latched), 64'hA5A500FF);
    chk("full_cnt0", 64'(shift_count), 64'd0);
    chk("full_row", 64'(latched_row), 64'd3);
    chk("full_errs", 64'({err_short, err_long, err_lat_oe}), 64'd0);
    chk("full_on", 64'(last_on_cycles), 64'd0);

    // short line
    shift_word(32'h0, 31);
    latch();
    chk("short_err", 64'(err_short), 64'd1);
    chk("short_nolong", 64'(err_long), 64'd0);
    tick(); tick(); tick();
    chk("short_sticky", 64'(err_short), 64'd1);
    clear();
    chk("short_clr", 64'(err_short), 64'd0);

    // long line with count saturation
    shift_bit(1'b1);
    w = 32'hFFFF0000;
    shift_word(w, 32);
    chk("long_cnt33", 64'(shift_count), 64'd33);
    shift_bit(1'b0);
    shift_bit(1'b0);
    chk("long_cntsat", 64'(shift_count), 64'd33);
    latch();
    chk("long_err", 64'(err_long), 64'd1);
    chk("long_noshort", 64'(err_short), 64'd0);
    chk("long_latched", 64'(latched), 64'hFFFC0000);
    clear();
    shift_bit(1'b1);
    shift_word(w, 32);
    latch();
    chk("long2_latched", 64'(latched), 64'hFFFF0000);
    chk("long2_err", 64'(err_long), 64'd1);
    clear();
    chk("long_clr", 64'(err_long), 64'd0);

    // on-time and lit gating
    chk("lit_off", 64'(lit), 64'h0);
    oe = 1'b0;
    tick();
    chk("lit_on", 64'(lit), 64'hFFFF0000);
    repeat (99) tick();
    oe = 1'b1;
    tick();
    chk("lit_off2", 64'(lit), 64'h0);
    latch();
    chk("on_100", 64'(last_on_cycles), 64'd100);
    clear();

    // shift and latch in the same cycle
    w = 32'h12345679;
    for (int i = 31; i >= 1; i--) shift_bit(w[i]);
    din = w[0];
    oclk = 1'b1;
    lat = 1'b1;
    tick();
    oclk = 1'b0;
    lat = 1'b0;
    tick();
    chk("sim_latched", 64'(latched), 64'h12345679);
    chk("sim_errs", 64'({err_short, err_long}), 64'd0);
    chk("sim_cnt", 64'(shift_count), 64'd0);

    // latch while displaying
    shift_word(32'h0, 32);
    oe = 1'b0;
    lat = 1'b1;
    tick();
    lat = 1'b0;
    oe = 1'b1;
    tick();
    chk("lat_oe_err", 64'(err_lat_oe), 64'd1);
    chk("lat_oe_on", 64'(last_on_cycles), 64'd1);

    // clr and a new error together: error wins
    shift_word(32'h0, 5);
    clr = 1'b1;
    lat = 1'b1;
    tick();
    clr = 1'b0;
    lat = 1'b0;
    tick();
    chk("clr_vs_err", 64'({err_short, err_lat_oe}), 64'b10);
    clear();

    // async reset mid-shift
    shift_word(32'hFFFFFFFF, 10);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    w = 32'h0F0F0F0F;
    row = 3'd0;
    shift_word(w, 32);
    latch();
    chk("rst_latched", 64'(latched), 64'h0F0F0F0F);
    chk("rst_errs", 64'({err_short, err_long, err_lat_oe}), 64'd0);
    chk("rst_row", 64'(latched_row), 64'd0);

    // row sequence, two latches per row
    count_en = 1'b1;
    for (int r = 0; r <= 8; r++) begin
      row = 3'(r % 8);
      latch();
      row = 3'(r + 3);
      tick();
      row = 3'(r % 8);
      latch();
    end
    tick(); tick();
    count_en = 1'b0;
    chk("row_strobes", 64'(rs_cnt), 64'd8);
    chk("frame_strobes", 64'(fs_cnt), 64'd1);
    chk("row_final", 64'(latched_row), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_panel_receiver.md
# display_panel_receiver

Receiving end of the LED matrix panel interface: consumes the serial `din`/`oclk`/`lat`/`oe`/`row` signal set produced by the display driver and reconstructs what a physical panel would show. It provides the latched row pixels, lit pixels, per-latch on-time and protocol-error flags. It sits on the driver outputs for in-system monitoring and loopback verification.

## Interface
- `rows`, 8: number of addressable rows.
- `columns`, 32: bits shifted per line.
- `countwidth`, 16: width of the on-time counters.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  1  serial pixel data, sampled on the detected `oclk` rising edge.
- `oclk`  in  1  shift clock, level sampled by `clk`.
- `lat`  in  1  latch strobe, active high.
- `oe`  in  1  output enable, active low.
- `row`  in  $clog2(rows)  row address.
- `clr`  in  1  synchronous clear of sticky error flags.
- `latched`  out  columns  latched row data.
- `latched_row`  out  $clog2(rows)  value of `row` at the last latch.
- `lit`  out  columns  `latched` gated by `oe`.
- `shift_count`  out  $clog2(columns+1)  shifts since the last latch, saturating at `columns`+1.
- `last_on_cycles`  out  countwidth  `oe`-low cycles between the previous latch and the most recent latch.
- `row_strobe`  out  1  one-cycle pulse when a latch changes `latched_row`.
- `frame_strobe`  out  1  one-cycle pulse when a latch moves `latched_row` from rows-1 to 0.
- `err_short`, `err_long`, `err_lat_oe`  out  1 each  sticky protocol errors.

## Operation
- Reset values: every output is 0. Internal `oclk_q`, `lat_q`, shift register `sr` and `on_cycles` are also reset to 0.
- Edge detection:
  - `oclk_rise` = `oclk` & ~`oclk_q`.
  - `lat_rise` = `lat` & ~`lat_q`.
  - `oclk_q` and `lat_q` are updated every cycle.
- Shift, on `oclk_rise`:
  - `sr` <= {`sr`[columns-2:0], `din`}.
  - `shift_count` increments, saturating at `columns`+1.
  - The first bit shifted after a latch ends up in `sr`[columns-1] after `columns` shifts.
- On-time count: each cycle with `oe`==0 and no `lat_rise`, `on_cycles` increments, saturating at 2^countwidth-1.
- Latch, on `lat_rise`:
  - `latched` <= the post-shift value of `sr`. If `oclk_rise` occurs in the same cycle, the new bit is included.
  - `latched_row` <= `row`.
  - `last_on_cycles` <= sat(`on_cycles` + (~`oe`)).
  - `on_cycles` <= 0.
  - `shift_count` <= 0. A simultaneous shift is counted for the error check and then discarded.
  - Error checks:
    - Shift count (including any simultaneous shift) < `columns` → `err_short` <= 1.
    - Shift count > `columns` → `err_long` <= 1.
    - `oe`==0 on the latch cycle → `err_lat_oe` <= 1.
  - `row_strobe` <= (`row` != `latched_row`).
  - `frame_strobe` <= (`latched_row`==rows-1 && `row`==0).
- `lit` <= `oe` ? 0 : `latched`, registered each cycle. On a latch cycle `lit` uses the old `latched`.
- Sticky flags clear only on `clr` or `rst`. When `clr` and a new error occur in the same cycle, the error wins.
- `row` is sampled only at latch; row changes between latches have no effect.
- A level-high `oclk` or `lat` held across cycles produces exactly one edge.

## Timing
- Detection latency:
  - `oclk` first seen high at cycle N: `sr` and `shift_count` update at N+1.
  - `lat` first seen high at cycle N: `latched`, `latched_row`, `last_on_cycles`, the strobes and the error flags update at N+1.
- `row_strobe` and `frame_strobe` are high for exactly one cycle, N+1.
- `lit` follows `oe` with 1 cycle latency.
- Minimum input pulse: 1 `clk` cycle high and 1 cycle low for both `oclk` and `lat`. The driver meets this by toggling `oclk` every cycle.
- No handshake and no back-pressure. Every edge is consumed in the cycle it is detected.
- Asynchronous reset mid-shift or mid-display drops the partial line. Counting restarts at 0 on the first `clk` edge after `rst` deasserts.

## Test plan
- Full line:
  - Stimulus: 32 shifts of 0xA5A500FF, MSB first, then `lat`.
  - Required: `latched`=0xA5A500FF, `shift_count`=0, no error flags set.
- Short line:
  - Stimulus: 31 shifts, then `lat`.
  - Required: `err_short`=1 and stays set until `clr`. `clr` returns it to 0 on the next cycle.
- Long line:
  - Stimulus: 33 shifts (1 followed by 0xFFFF0000), then `lat`.
  - Required: `err_long`=1, `latched`=0xFFFF0000.
- On-time:
  - Stimulus: `oe` low for 100 cycles, `oe` high, then `lat`.
  - Required: `last_on_cycles`=100. `lit` equals `latched` only while `oe` is low, delayed 1 cycle.
- Row sequence:
  - Stimulus: latches at rows 0,1,…,7,0 while holding each row for 2 latches.
  - Required: `row_strobe` fires 8 times; `frame_strobe` fires once, on the 7→0 latch.
- Reset and latch errors:
  - Stimulus: assert `rst` after 10 shifts.
  - Required: all outputs 0 immediately. A following 32-shift line latches cleanly with no errors.
  - Stimulus: latch with `oe`=0.
  - Required: `err_lat_oe`=1.
